// File: rtl/resp_serializer_pkg.sv
// Shared types and constants for the response serializer.
package resp_serializer_pkg;

  // Serializer control states.
  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_SEND = 1'b1
  } ser_state_t;

  // Maximum number of bytes in one ALU result.
  localparam int unsigned RESP_MAX_BYTES = 8;

endpackage

// File: rtl/resp_serializer_tx_out_reg.sv
// 8-bit ready/valid output register feeding the UART TX byte interface.
module tx_out_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       ready_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       free_o
);

  logic [7:0] data_q;
  logic       valid_q;

  // Register can take a new byte when empty or being drained this cycle.
  always_comb begin
    free_o = ~valid_q | ready_i;
  end

  // Load on request, clear valid once consumed, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/resp_serializer.sv
// Merges echo bytes and LSB-first ALU results onto one registered TX byte stream.
module resp_serializer
  import resp_serializer_pkg::*;
#(
  parameter int unsigned RES_W = RESP_MAX_BYTES * 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RES_W-1:0] result_i,
  input  logic [3:0]       result_len_i,
  input  logic             result_valid_i,
  output logic             result_ready_o,
  input  logic [7:0]       echo_data_i,
  input  logic             echo_valid_i,
  output logic             echo_ready_o,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic             busy_o
);

  localparam int unsigned RES_BYTES = RES_W / 8;
  localparam int unsigned CNT_W     = $clog2(RES_BYTES + 1);

  ser_state_t       state_q, state_d;
  logic [RES_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_c;
  logic             or_free;
  logic             or_load;
  logic [7:0]       or_data;

  tx_out_reg u_out (
    .clk     (clk),
    .rst     (rst),
    .load_i  (or_load),
    .data_i  (or_data),
    .ready_i (tx_ready_i),
    .data_o  (tx_data_o),
    .valid_o (tx_valid_o),
    .free_o  (or_free)
  );

  // Clamp the requested length to the result width.
  always_comb begin
    if (int'(result_len_i) > int'(RES_BYTES)) len_c = CNT_W'(RES_BYTES);
    else                                      len_c = CNT_W'(result_len_i);
  end

  // Next-state, handshakes and output-register load selection.
  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    cnt_d          = cnt_q;
    or_load        = 1'b0;
    or_data        = '0;
    result_ready_o = 1'b0;
    echo_ready_o   = 1'b0;
    unique case (state_q)
      SER_IDLE: begin
        result_ready_o = 1'b1;
        echo_ready_o   = ~result_valid_i & or_free;
        if (result_valid_i) begin
          if (len_c != '0) begin
            // Byte 0 bypasses the shift register when the output is free,
            // so it reaches TX one cycle after acceptance.
            if (or_free) begin
              or_load = 1'b1;
              or_data = result_i[7:0];
              shift_d = result_i >> 8;
              cnt_d   = len_c - CNT_W'(1);
              state_d = (len_c == CNT_W'(1)) ? SER_IDLE : SER_SEND;
            end else begin
              shift_d = result_i;
              cnt_d   = len_c;
              state_d = SER_SEND;
            end
          end
        end else if (echo_valid_i && or_free) begin
          or_load = 1'b1;
          or_data = echo_data_i;
        end
      end
      SER_SEND: begin
        if (or_free) begin
          or_load = 1'b1;
          or_data = shift_q[7:0];
          shift_d = shift_q >> 8;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = SER_IDLE;
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

  // State, shift register and remaining-byte count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SER_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Busy while result bytes are pending or a byte sits in the output register.
  always_comb begin
    busy_o = (state_q == SER_SEND) | tx_valid_o;
  end

endmodule

// File: tb/tb_resp_serializer.sv
// Randomized and directed bench for resp_serializer against a byte-queue model.
module tb_resp_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] result_i = '0;
  logic [3:0]  result_len_i = '0;
  logic        result_valid_i = 1'b0;
  logic        result_ready_o;
  logic [7:0]  echo_data_i = '0;
  logic        echo_valid_i = 1'b0;
  logic        echo_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b1;
  logic        busy_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: the TX slot plus a queue of result bytes not yet in it.
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = '0;
  logic [7:0] m_pend[$];
  logic [7:0] obs[$];

  always #5 clk = ~clk;

  resp_serializer #(.RES_W(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .result_i       (result_i),
    .result_len_i   (result_len_i),
    .result_valid_i (result_valid_i),
    .result_ready_o (result_ready_o),
    .echo_data_i    (echo_data_i),
    .echo_valid_i   (echo_valid_i),
    .echo_ready_o   (echo_ready_o),
    .tx_data_o      (tx_data_o),
    .tx_valid_o     (tx_valid_o),
    .tx_ready_i     (tx_ready_i),
    .busy_o         (busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: check registered outputs, drive inputs, check readies, advance model.
  task automatic step(input logic rv, input logic [63:0] res, input logic [3:0] len,
                      input logic ev, input logic [7:0] ed, input logic txr,
                      input logic r, output logic ea);
    logic free, busyres, er, loaded;
    int unsigned n;
    @(negedge clk);
    chk("tx_valid", tx_valid_o, m_valid);
    chk("tx_data", tx_data_o, m_data);
    chk("busy", busy_o, m_valid || (m_pend.size() != 0));
    rst = r; result_valid_i = rv; result_i = res; result_len_i = len;
    echo_valid_i = ev; echo_data_i = ed; tx_ready_i = txr;
    #1;
    free    = !m_valid || txr;
    busyres = (m_pend.size() != 0);
    er      = !busyres && !rv && free;
    chk("result_ready", result_ready_o, !busyres);
    chk("echo_ready", echo_ready_o, er);
    ea = !r && ev && er;
    if (tx_valid_o && txr && !r) obs.push_back(tx_data_o);
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0; m_data = '0; m_pend.delete();
    end else begin
      loaded = 1'b0;
      if (!busyres && rv) begin
        n = (len > 8) ? 8 : len;
        for (int unsigned i = 0; i < n; i++) m_pend.push_back(res[8*i +: 8]);
      end else if (ea) begin
        m_data = ed; m_valid = 1'b1; loaded = 1'b1;
      end
      if (!loaded && free) begin
        if (m_pend.size() != 0) begin
          m_data = m_pend.pop_front(); m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input int unsigned cycles, input logic txr);
    logic ea;
    for (int unsigned i = 0; i < cycles; i++) step(0, '0, 0, 0, '0, txr, 0, ea);
  endtask

  task automatic cmp_obs(input string tag, input logic [7:0] exp[$]);
    chk({tag, "_count"}, obs.size(), exp.size());
    for (int unsigned i = 0; i < exp.size() && i < obs.size(); i++)
      chk(tag, obs[i], exp[i]);
    obs.delete();
  endtask

  initial begin
    logic ea;
    logic [63:0] r8;
    logic [63:0] rd;
    r8 = 64'h0807060504030201;
    rd = 64'h00000000DEADBEEF;

    // Reset behaviour.
    step(0, '0, 0, 0, '0, 1, 1, ea);
    step(0, '0, 0, 0, '0, 1, 1, ea);
    step(0, '0, 0, 0, '0, 1, 0, ea);
    chk("rst_tx_valid", tx_valid_o, 1'b0);
    chk("rst_tx_data", tx_data_o, 8'h00);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_result_ready", result_ready_o, 1'b1);
    obs.delete();

    // Full 8-byte result, back-to-back.
    step(1, r8, 8, 0, '0, 1, 0, ea);
    idle(10, 1);
    cmp_obs("len8", '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08});

    // 4-byte result under toggling ready.
    step(1, r8, 4, 0, '0, 1, 0, ea);
    for (int unsigned i = 0; i < 12; i++) step(0, '0, 0, 0, '0, i[0], 0, ea);
    idle(2, 1);
    cmp_obs("len4_stall", '{8'h01, 8'h02, 8'h03, 8'h04});

    // Simultaneous result and echo: result wins, echo follows.
    ea = 1'b0;
    step(1, rd, 4, 1, 8'hAA, 1, 0, ea);
    for (int unsigned i = 0; i < 20 && !ea; i++) step(0, '0, 0, 1, 8'hAA, 1, 0, ea);
    chk("echo_accepted", ea, 1'b1);
    idle(3, 1);
    cmp_obs("priority", '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hAA});

    // Echo stream back-to-back.
    step(0, '0, 0, 1, 8'h41, 1, 0, ea);
    step(0, '0, 0, 1, 8'h42, 1, 0, ea);
    step(0, '0, 0, 1, 8'h43, 1, 0, ea);
    idle(3, 1);
    cmp_obs("echo", '{8'h41, 8'h42, 8'h43});

    // Zero-length result is dropped; oversize length clamps to 8.
    step(1, r8, 0, 0, '0, 1, 0, ea);
    idle(3, 1);
    cmp_obs("len0", '{});
    step(1, r8, 12, 0, '0, 1, 0, ea);
    idle(12, 1);
    cmp_obs("len12", '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08});

    // Reset after three bytes delivered.
    step(1, r8, 8, 0, '0, 1, 0, ea);
    idle(3, 1);
    step(0, '0, 0, 0, '0, 0, 1, ea);
    #1;
    chk("midrst_tx_valid", tx_valid_o, 1'b0);
    chk("midrst_busy", busy_o, 1'b0);
    idle(10, 1);
    cmp_obs("midrst", '{8'h01, 8'h02, 8'h03});

    // Randomized traffic checked cycle by cycle against the model.
    for (int unsigned i = 0; i < 2000; i++) begin
      step($urandom_range(0, 9) < 3, {$urandom, $urandom}, 4'($urandom_range(0, 15)),
           $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 9) < 7,
           $urandom_range(0, 99) < 2, ea);
    end
    idle(20, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
